systolic_feeder: RTL and testbench

Operand-injection stage directly upstream of the 4x4 systolic PE array. It accepts one NxN tile of A, column-beat by column-beat, and one NxN tile of B, row-beat by row-beat, through a valid/ready handshake into ping-pong banks. On a go request it streams the tile into the array's west edge (row lanes) and north edge (column lanes) with diagonal skew: lane k is delayed k cycles and zero-padded. It pulses a start strobe to the controller.

---
 rtl/systolic_feeder_pkg.sv | 24 ++
 rtl/systolic_feeder_bank.sv | 63 ++++++
 rtl/systolic_feeder.sv | 169 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_feeder_pkg
// Shared constants and types for the operand feeder of the 4x4 systolic
// PE array.
//   N          : array dimension (lanes per edge, beats per tile)
//   NUM_BITS   : operand element width
//   STREAM_LEN : cycles needed to push one skewed tile into the array
//   BEAT_W     : width of the load beat index
//   T_W        : width of the stream cycle counter
// ---------------------------------------------------------------------------
package systolic_feeder_pkg;

   localparam int N          = 4;
   localparam int NUM_BITS   = 8;
   localparam int STREAM_LEN = 2 * N - 1;
   localparam int BEAT_W     = $clog2(N);
   localparam int T_W        = $clog2(STREAM_LEN);

   typedef enum logic {
      FEED_IDLE,
      FEED_STREAM
   } feed_state_e;

endpackage

// File: rtl/systolic_feeder_bank.sv
// ---------------------------------------------------------------------------
// feeder_bank
// Ping-pong tile storage for one operand (two NxN tiles). Beats are written
// whole by beat index. The read port returns the diagonally skewed edge
// vector for stream cycle t: lane l carries element l of beat (t-l) when
// that beat exists, otherwise zero. This one shape serves both edges:
//   A loaded column-beat by column-beat -> lane i = A[i][t-i]
//   B loaded row-beat by row-beat       -> lane j = B[t-j][j]
// Ports:
//   clk_i       clock
//   wr_en_i     write the beat on wr_vec_i
//   wr_bank_i   bank written
//   wr_beat_i   beat index written
//   wr_vec_i    N lanes of NUM_BITS
//   rd_bank_i   bank read
//   rd_t_i      stream cycle 0..STREAM_LEN-1
//   rd_lanes_o  skewed, zero-padded lanes
// ---------------------------------------------------------------------------
module feeder_bank
   import systolic_feeder_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    wr_en_i,
   input  logic                    wr_bank_i,
   input  logic [BEAT_W-1:0]       wr_beat_i,
   input  logic [N*NUM_BITS-1:0]   wr_vec_i,
   input  logic                    rd_bank_i,
   input  logic [T_W-1:0]          rd_t_i,
   output logic [N*NUM_BITS-1:0]   rd_lanes_o
);

   // Pure data storage: validity is tracked by the full flags in the top
   // level, so no reset is needed here.
   logic [N*NUM_BITS-1:0] mem_q [2][N];
   logic [N*NUM_BITS-1:0] mem_d [2][N];
   logic [BEAT_W-1:0]     beat_idx;

   always_comb begin
      mem_d = mem_q;
      if (wr_en_i) begin
         mem_d[wr_bank_i][wr_beat_i] = wr_vec_i;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Lane l lags the stream counter by l cycles; outside its N-beat window
   // the lane is padded with zero.
   always_comb begin
      rd_lanes_o = '0;
      beat_idx   = '0;
      for (int l = 0; l < N; l++) begin
         if ((int'(rd_t_i) >= l) && (int'(rd_t_i) < l + N)) begin
            beat_idx = BEAT_W'(int'(rd_t_i) - l);
            rd_lanes_o[l*NUM_BITS +: NUM_BITS] =
               mem_q[rd_bank_i][beat_idx][l*NUM_BITS +: NUM_BITS];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Operand-injection stage in front of the NxN systolic PE array. Loads one
// A tile and one B tile per handshake sequence into ping-pong banks, then on
// go streams them into the west (left_o) and north (top_o) array edges with
// diagonal skew, pulsing feed_start_o on the first stream cycle.
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-low reset
//   in_valid_i    load beat valid
//   in_ready_o    load beat accepted when valid & ready (write bank not full)
//   a_vec_i       beat k: lane i = A[i][k]
//   b_vec_i       beat k: lane j = B[k][j]
//   go_i          controller permits next tile stream
//   left_o        lane i drives array row i
//   top_o         lane j drives array column j
//   feed_valid_o  high on every stream cycle
//   feed_start_o  one-cycle pulse on stream cycle 0
// ---------------------------------------------------------------------------
module systolic_feeder
   import systolic_feeder_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [N*NUM_BITS-1:0]   a_vec_i,
   input  logic [N*NUM_BITS-1:0]   b_vec_i,
   input  logic                    go_i,
   output logic [N*NUM_BITS-1:0]   left_o,
   output logic [N*NUM_BITS-1:0]   top_o,
   output logic                    feed_valid_o,
   output logic                    feed_start_o
);

   localparam logic [T_W-1:0]    LAST_T    = T_W'(STREAM_LEN - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

   feed_state_e           state_q, state_d;
   logic [T_W-1:0]        t_q, t_d;
   logic                  rd_bank_q, rd_bank_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [BEAT_W-1:0]     ld_cnt_q, ld_cnt_d;
   logic [1:0]            full_q, full_d;
   logic [N*NUM_BITS-1:0] left_q, left_d;
   logic [N*NUM_BITS-1:0] top_q, top_d;
   logic                  valid_q, valid_d;
   logic                  start_q, start_d;

   logic                  accept;
   logic [N*NUM_BITS-1:0] a_lanes;
   logic [N*NUM_BITS-1:0] b_lanes;

   assign in_ready_o = ~full_q[wr_bank_q];
   assign accept     = in_valid_i & in_ready_o;

   // Banks are read with the next-cycle pointer and counter so the edge
   // registers hold the value for the cycle they are presented on.
   feeder_bank u_bank_a (
      .clk_i      (clk_i),
      .wr_en_i    (accept),
      .wr_bank_i  (wr_bank_q),
      .wr_beat_i  (ld_cnt_q),
      .wr_vec_i   (a_vec_i),
      .rd_bank_i  (rd_bank_d),
      .rd_t_i     (t_d),
      .rd_lanes_o (a_lanes)
   );

   feeder_bank u_bank_b (
      .clk_i      (clk_i),
      .wr_en_i    (accept),
      .wr_bank_i  (wr_bank_q),
      .wr_beat_i  (ld_cnt_q),
      .wr_vec_i   (b_vec_i),
      .rd_bank_i  (rd_bank_d),
      .rd_t_i     (t_d),
      .rd_lanes_o (b_lanes)
   );

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      rd_bank_d = rd_bank_q;
      wr_bank_d = wr_bank_q;
      ld_cnt_d  = ld_cnt_q;
      full_d    = full_q;
      valid_d   = 1'b0;

      // Load side: only ever touches the (non-full) write bank.
      if (accept) begin
         if (ld_cnt_q == LAST_BEAT) begin
            ld_cnt_d          = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
         end
      end

      // Stream side: only ever touches the (full) read bank, so the two
      // full-flag updates never collide.
      unique case (state_q)
         FEED_IDLE: begin
            if (go_i && full_q[rd_bank_q]) begin
               state_d = FEED_STREAM;
               t_d     = '0;
               valid_d = 1'b1;
            end
         end
         FEED_STREAM: begin
            if (t_q == LAST_T) begin
               full_d[rd_bank_q] = 1'b0;
               rd_bank_d         = ~rd_bank_q;
               // Chain straight into the other bank with no bubble.
               if (go_i && full_q[~rd_bank_q]) begin
                  t_d     = '0;
                  valid_d = 1'b1;
               end else begin
                  state_d = FEED_IDLE;
                  t_d     = '0;
               end
            end else begin
               t_d     = t_q + 1'b1;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = FEED_IDLE;
         end
      endcase

      start_d = valid_d && (t_d == '0);
      left_d  = valid_d ? a_lanes : '0;
      top_d   = valid_d ? b_lanes : '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= FEED_IDLE;
         t_q       <= '0;
         rd_bank_q <= 1'b0;
         wr_bank_q <= 1'b0;
         ld_cnt_q  <= '0;
         full_q    <= '0;
         left_q    <= '0;
         top_q     <= '0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         rd_bank_q <= rd_bank_d;
         wr_bank_q <= wr_bank_d;
         ld_cnt_q  <= ld_cnt_d;
         full_q    <= full_d;
         left_q    <= left_d;
         top_q     <= top_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
      end
   end

   assign left_o       = left_q;
   assign top_o        = top_q;
   assign feed_valid_o = valid_q;
   assign feed_start_o = start_q;

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
   import systolic_feeder_pkg::*;

   localparam int W  = N * NUM_BITS;
   localparam int NT = 10;

   logic         clk;
   logic         rst_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [W-1:0] a_vec_i;
   logic [W-1:0] b_vec_i;
   logic         go_i;
   logic [W-1:0] left_o;
   logic [W-1:0] top_o;
   logic         feed_valid_o;
   logic         feed_start_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference tiles: ma[tile][i][k] = A[i][k], mb[tile][k][j] = B[k][j]
   logic [NUM_BITS-1:0] ma [NT][N][N];
   logic [NUM_BITS-1:0] mb [NT][N][N];
   logic [W-1:0] cap_left [STREAM_LEN];
   logic [W-1:0] cap_top  [STREAM_LEN];

   systolic_feeder dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .a_vec_i      (a_vec_i),
      .b_vec_i      (b_vec_i),
      .go_i         (go_i),
      .left_o       (left_o),
      .top_o        (top_o),
      .feed_valid_o (feed_valid_o),
      .feed_start_o (feed_start_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time exceeded, required completion");
      $fatal(1, "timeout");
   end

   // Skewed edge contents straight from the array-feeding rule.
   function automatic logic [W-1:0] exp_left(input int idx, input int t);
      logic [W-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*NUM_BITS +: NUM_BITS] = ma[idx][i][t-i];
      return v;
   endfunction

   function automatic logic [W-1:0] exp_top(input int idx, input int t);
      logic [W-1:0] v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) v[j*NUM_BITS +: NUM_BITS] = mb[idx][t-j][j];
      return v;
   endfunction

   task automatic fill_random(input int idx);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[idx][r][c] = NUM_BITS'($urandom_range(1, 255));
            mb[idx][r][c] = NUM_BITS'($urandom_range(1, 255));
         end
   endtask

   // Called at a negedge; returns at a negedge after the last beat accepted.
   task automatic load_beats(input int idx, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         int w = 0;
         for (int l = 0; l < N; l++) begin
            a_vec_i[l*NUM_BITS +: NUM_BITS] = ma[idx][l][k];
            b_vec_i[l*NUM_BITS +: NUM_BITS] = mb[idx][k][l];
         end
         in_valid_i = 1'b1;
         while (in_ready_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (in_ready_o !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL load_ready_timeout tile %0d beat %0d: in_ready_o=%b, required 1", idx, k, in_ready_o);
            in_valid_i = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid_i = 1'b0;
   endtask

   task automatic load_tile(input int idx);
      load_beats(idx, 0, N - 1);
   endtask

   // Waits (bounded) for a stream, then checks all STREAM_LEN cycles.
   task automatic watch_stream(input int idx, input int max_wait, input string tag);
      int w = 0;
      while (feed_valid_o !== 1'b1 && w < max_wait) begin
         @(negedge clk);
         w++;
      end
      n_tests++;
      if (feed_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s stream_begin: feed_valid_o=%b after %0d cycles, required 1", tag, feed_valid_o, w);
         return;
      end
      for (int t = 0; t < STREAM_LEN; t++) begin
         cap_left[t] = left_o;
         cap_top[t]  = top_o;
         n_tests++;
         if (feed_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid t=%0d: got %b, required 1", tag, t, feed_valid_o);
         end
         n_tests++;
         if (feed_start_o !== (t == 0)) begin
            n_fail++;
            $display("FAIL %s start t=%0d: got %b, required %b", tag, t, feed_start_o, (t == 0));
         end
         n_tests++;
         if (left_o !== exp_left(idx, t)) begin
            n_fail++;
            $display("FAIL %s left t=%0d: got %h, required %h", tag, t, left_o, exp_left(idx, t));
         end
         n_tests++;
         if (top_o !== exp_top(idx, t)) begin
            n_fail++;
            $display("FAIL %s top t=%0d: got %h, required %h", tag, t, top_o, exp_top(idx, t));
         end
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         n_tests++;
         if (feed_valid_o !== 1'b0 || feed_start_o !== 1'b0 || left_o !== '0 || top_o !== '0) begin
            n_fail++;
            $display("FAIL %s idle c=%0d: valid=%b start=%b left=%h top=%h, required all 0",
                     tag, c, feed_valid_o, feed_start_o, left_o, top_o);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (left_o !== '0 || top_o !== '0 || feed_valid_o !== 1'b0 || feed_start_o !== 1'b0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold: left=%h top=%h valid=%b start=%b ready=%b, required 0/0/0/0/1",
                  left_o, top_o, feed_valid_o, feed_start_o, in_ready_o);
      end
      rst_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready_o);
      end
      check_idle("reset_release", 2);
   endtask

   task automatic test_single_tile();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[0][r][c] = NUM_BITS'(16 * r + c);
            mb[0][r][c] = NUM_BITS'(8'h80 + 4 * r + c);
         end
      load_tile(0);
      check_idle("single_pre_go", 2);
      go_i = 1'b1;
      @(negedge clk);
      watch_stream(0, 0, "single");
      n_tests++;
      if (cap_left[0] !== 32'h0000_0000 || cap_top[0] !== 32'h0000_0080) begin
         n_fail++;
         $display("FAIL single_t0: left=%h top=%h, required 00000000 00000080", cap_left[0], cap_top[0]);
      end
      n_tests++;
      if (cap_left[3] !== 32'h3021_1203 || cap_top[3] !== 32'h8386_898C) begin
         n_fail++;
         $display("FAIL single_t3: left=%h top=%h, required 30211203 8386898c", cap_left[3], cap_top[3]);
      end
      n_tests++;
      if (cap_left[6] !== 32'h3300_0000 || cap_top[6] !== 32'h8F00_0000) begin
         n_fail++;
         $display("FAIL single_t6: left=%h top=%h, required 33000000 8f000000", cap_left[6], cap_top[6]);
      end
      check_idle("single_post", 3);
      go_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      fill_random(1);
      fill_random(2);
      load_tile(1);
      go_i = 1'b1;
      fork
         begin
            watch_stream(1, 10, "b2b_first");
            watch_stream(2, 0, "b2b_second");
         end
         load_tile(2);
      join
      go_i = 1'b0;
      check_idle("b2b_post", 3);
   endtask

   task automatic test_backpressure();
      fill_random(3);
      fill_random(4);
      fill_random(5);
      load_tile(3);
      load_tile(4);
      for (int l = 0; l < N; l++) begin
         a_vec_i[l*NUM_BITS +: NUM_BITS] = ma[5][l][0];
         b_vec_i[l*NUM_BITS +: NUM_BITS] = mb[5][0][l];
      end
      in_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_tests++;
         if (in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_full c=%0d: got %b, required 0", c, in_ready_o);
         end
         @(negedge clk);
      end
      go_i = 1'b1;
      watch_stream(3, 10, "bp_first");
      n_tests++;
      if (in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_freed: got %b, required 1", in_ready_o);
      end
      fork
         load_tile(5);
         begin
            watch_stream(4, 0, "bp_second");
            watch_stream(5, 0, "bp_held_tile");
         end
      join
      go_i = 1'b0;
      check_idle("bp_post", 3);
   endtask

   task automatic test_partial_go();
      fill_random(6);
      go_i = 1'b1;
      check_idle("go_empty", 5);
      load_beats(6, 0, 1);
      check_idle("go_partial", 5);
      fork
         load_beats(6, 2, N - 1);
         watch_stream(6, 20, "partial_complete");
      join
      go_i = 1'b0;
      check_idle("partial_post", 2);
   endtask

   task automatic test_reset_mid_stream();
      int w = 0;
      fill_random(7);
      fill_random(8);
      fill_random(9);
      load_tile(7);
      load_tile(8);
      n_tests++;
      if (in_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_both_full: in_ready_o=%b, required 0", in_ready_o);
      end
      go_i = 1'b1;
      while (feed_valid_o !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (feed_valid_o !== 1'b1 || left_o !== exp_left(7, 3)) begin
         n_fail++;
         $display("FAIL rst_mid_t3: valid=%b left=%h, required 1 %h", feed_valid_o, left_o, exp_left(7, 3));
      end
      rst_i = 1'b0;
      go_i  = 1'b0;
      #1;
      n_tests++;
      if (left_o !== '0 || top_o !== '0 || feed_valid_o !== 1'b0 || feed_start_o !== 1'b0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_async: left=%h top=%h valid=%b start=%b ready=%b, required 0/0/0/0/1",
                  left_o, top_o, feed_valid_o, feed_start_o, in_ready_o);
      end
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      load_tile(9);
      go_i = 1'b1;
      watch_stream(9, 10, "rst_fresh");
      check_idle("rst_discarded", 4);
      go_i = 1'b0;
   endtask

   initial begin
      rst_i      = 1'b0;
      in_valid_i = 1'b0;
      a_vec_i    = '0;
      b_vec_i    = '0;
      go_i       = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_tile();
      test_back_to_back();
      test_backpressure();
      test_partial_go();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
